hdmi_pattern_gen: RTL and testbench

Parametrised, multi-mode video test-pattern source for the HDMI path, clocked by `clk_pixel`. It generalises the fixed border test pattern to configurable coordinate and colour widths. It adds five patterns (border, colour bars, scrolling checkerboard, animated grey ramp, black), frame-synchronous mode switching and a frame counter. It consumes the `cx`/`cy` and geometry outputs of the `hdmi` core and drives its `rgb` input.

---
 rtl/hdmi_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern source for the HDMI path: border, colour bars, scrolling
// checkerboard, animated grey ramp and black, with mode switching and a
// frame counter that both update only at frame start (cx==0 && cy==0).
//
// Ports:
//   clk_pixel, reset      pixel clock, synchronous active-high reset
//   mode                  requested pattern, latched at frame start
//   cx, cy                current pixel position from the hdmi core
//   screen_start_x/y      first active column/row
//   frame_width/height    total frame size
//   screen_width/height   active area size
//   rgb                   {R,G,B} pixel, one cycle after cx/cy
//   active_mode           pattern currently rendered
//   frame_count           frames started since reset (wraps)
module hdmi_pattern_gen #(
  parameter int unsigned BIT_WIDTH    = 10,
  parameter int unsigned BIT_HEIGHT   = 10,
  parameter int unsigned COLOR_DEPTH  = 8,
  parameter int unsigned CHECKER_LOG2 = 5,
  parameter int unsigned SCROLL_STEP  = 1
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic [2:0]               mode,
  input  logic [BIT_WIDTH-1:0]     cx,
  input  logic [BIT_WIDTH-1:0]     screen_start_x,
  input  logic [BIT_WIDTH-1:0]     frame_width,
  input  logic [BIT_WIDTH-1:0]     screen_width,
  input  logic [BIT_HEIGHT-1:0]    cy,
  input  logic [BIT_HEIGHT-1:0]    screen_start_y,
  input  logic [BIT_HEIGHT-1:0]    frame_height,
  input  logic [BIT_HEIGHT-1:0]    screen_height,
  output logic [3*COLOR_DEPTH-1:0] rgb,
  output logic [2:0]               active_mode,
  output logic [15:0]              frame_count
);

  localparam int unsigned CW   = COLOR_DEPTH;
  localparam int unsigned RGBW = 3 * COLOR_DEPTH;
  localparam int unsigned AW   = BIT_WIDTH + 1;
  localparam logic [BIT_WIDTH-1:0] STEP = BIT_WIDTH'(SCROLL_STEP);
  localparam logic [CW-1:0]        WHT  = {CW{1'b1}};
  localparam logic [CW-1:0]        BLK  = {CW{1'b0}};

  // Registered state
  logic [RGBW-1:0] rgb_q, rgb_d;
  logic [2:0]      active_mode_q, active_mode_d;
  logic [15:0]     frame_count_q, frame_count_d;
  logic [2:0]      bar_q, bar_d;
  logic [AW-1:0]   acc_q, acc_d;

  // Combinational helpers
  logic                  fs;
  logic                  in_active;
  logic                  line_start;
  logic [BIT_WIDTH-1:0]  k;
  logic [BIT_HEIGHT-1:0] j;
  logic [BIT_WIDTH-1:0]  s;
  logic [BIT_WIDTH-1:0]  ks;
  logic [2:0]            bar_cur;
  logic [AW-1:0]         acc_cur;
  logic [AW-1:0]         acc_sum;
  logic [AW-1:0]         width_ext;
  logic [CW-1:0]         r_c, g_c, b_c;
  logic [RGBW-1:0]       pix;

  // Only single bits of some offsets are consumed; screen_height is informational.
  logic geom_unused;
  assign geom_unused = ^{screen_height, ks, j};

  // Standard bar order: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [RGBW-1:0] bar_color(input logic [2:0] b);
    case (b)
      3'd0:    bar_color = {WHT, WHT, WHT};
      3'd1:    bar_color = {WHT, WHT, BLK};
      3'd2:    bar_color = {BLK, WHT, WHT};
      3'd3:    bar_color = {BLK, WHT, BLK};
      3'd4:    bar_color = {WHT, BLK, WHT};
      3'd5:    bar_color = {WHT, BLK, BLK};
      3'd6:    bar_color = {BLK, BLK, WHT};
      default: bar_color = {BLK, BLK, BLK};
    endcase
  endfunction

  // Next-state and pixel generation
  always_comb begin
    fs         = (cx == '0) && (cy == '0);
    k          = cx - screen_start_x;
    j          = cy - screen_start_y;
    in_active  = (cx >= screen_start_x) && (cy >= screen_start_y);
    line_start = (cx == screen_start_x);
    s          = BIT_WIDTH'(frame_count_q) * STEP;
    ks         = k + s;
    width_ext  = {1'b0, screen_width};

    // Bar index tracks floor(8k/screen_width): acc holds 8k mod screen_width
    // and is stepped by 8 per pixel, so no divider is needed.
    bar_cur = line_start ? 3'd0 : bar_q;
    acc_cur = line_start ? '0 : acc_q;
    acc_sum = acc_cur + AW'(8);
    bar_d   = bar_cur;
    acc_d   = acc_cur;
    if (bar_cur != 3'd7) begin
      if (acc_sum >= width_ext) begin
        bar_d = bar_cur + 3'd1;
        acc_d = acc_sum - width_ext;
      end else begin
        acc_d = acc_sum;
      end
    end

    // Border channels
    r_c = (cx == screen_start_x) ? WHT : BLK;
    g_c = (cy == screen_start_y) ? WHT : BLK;
    b_c = ((cx == (frame_width - BIT_WIDTH'(1))) ||
           (cy == (frame_height - BIT_HEIGHT'(1)))) ? WHT : BLK;

    pix = '0;
    case (active_mode_q)
      3'd0: pix = {r_c, g_c, b_c};
      3'd1: if (in_active) pix = bar_color(bar_cur);
      3'd2: if (in_active && (ks[CHECKER_LOG2] ^ j[CHECKER_LOG2])) pix = {RGBW{1'b1}};
      3'd3: if (in_active) pix = {3{CW'(ks)}};
      default: pix = '0;
    endcase

    rgb_d         = pix;
    active_mode_d = fs ? mode : active_mode_q;
    frame_count_d = fs ? frame_count_q + 16'd1 : frame_count_q;
  end

  // State register
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb_q         <= '0;
      active_mode_q <= 3'd0;
      frame_count_q <= 16'd0;
      bar_q         <= 3'd0;
      acc_q         <= '0;
    end else begin
      rgb_q         <= rgb_d;
      active_mode_q <= active_mode_d;
      frame_count_q <= frame_count_d;
      bar_q         <= bar_d;
      acc_q         <= acc_d;
    end
  end

  assign rgb         = rgb_q;
  assign active_mode = active_mode_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Directed bench for hdmi_pattern_gen with 640x480 geometry
// (frame 800x525, active area starting at (160,45)) and SCROLL_STEP=32.
module tb_hdmi_pattern_gen;

  logic        clk_pixel;
  logic        reset;
  logic [2:0]  mode;
  logic [9:0]  cx, cy;
  logic [9:0]  screen_start_x, frame_width, screen_width;
  logic [9:0]  screen_start_y, frame_height, screen_height;
  logic [23:0] rgb;
  logic [2:0]  active_mode;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  hdmi_pattern_gen #(.SCROLL_STEP(32)) dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .mode           (mode),
    .cx             (cx),
    .screen_start_x (screen_start_x),
    .frame_width    (frame_width),
    .screen_width   (screen_width),
    .cy             (cy),
    .screen_start_y (screen_start_y),
    .frame_height   (frame_height),
    .screen_height  (screen_height),
    .rgb            (rgb),
    .active_mode    (active_mode),
    .frame_count    (frame_count)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // Present one pixel position, clock it, sample 1 time unit after the edge.
  task automatic step(input int x, input int y);
    cx = 10'(x);
    cy = 10'(y);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic fs_pump(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    int cnt [8];
    int b;
    logic [23:0] e;

    reset          = 1'b1;
    mode           = 3'd0;
    cx             = 10'd0;
    cy             = 10'd0;
    screen_start_x = 10'd160;
    frame_width    = 10'd800;
    screen_width   = 10'd640;
    screen_start_y = 10'd45;
    frame_height   = 10'd525;
    screen_height  = 10'd480;

    // Reset held mid-frame, then an FS while still in reset
    step(300, 200);
    step(301, 200);
    chk("reset_rgb", rgb, 24'h0);
    chk("reset_fc", {8'h0, frame_count}, 24'd0);
    chk("reset_mode", {21'h0, active_mode}, 24'd0);
    step(0, 0);
    chk("reset_fs_fc", {8'h0, frame_count}, 24'd0);

    // Border mode right after release
    reset = 1'b0;
    step(160, 100);
    chk("border_r", rgb, 24'hFF0000);
    step(799, 45);
    chk("border_gb", rgb, 24'h00FFFF);
    step(160, 45);
    chk("border_rg", rgb, 24'hFFFF00);
    step(300, 524);
    chk("border_b_bottom", rgb, 24'h0000FF);
    step(300, 300);
    chk("border_none", rgb, 24'h000000);

    // Mid-frame mode request has no effect before FS
    mode = 3'd1;
    step(300, 200);
    chk("midframe_rgb", rgb, 24'h000000);
    chk("midframe_mode", {21'h0, active_mode}, 24'd0);
    step(160, 300);
    chk("midframe_still_border", rgb, 24'hFF0000);
    chk("midframe_fc", {8'h0, frame_count}, 24'd0);

    // FS latches the new mode and counts the frame
    step(0, 0);
    chk("fs_pixel_border", rgb, 24'h000000);
    chk("fs_mode", {21'h0, active_mode}, 24'd1);
    chk("fs_fc", {8'h0, frame_count}, 24'd1);

    // Colour bars across one full line at cy=100
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int x = 0; x < 800; x++) begin
      step(x, 100);
      if (x < 160) begin
        e = 24'h0;
      end else begin
        b = (x - 160) / 80;
        if (b > 7) b = 7;
        e = bars[b];
        for (int i = 0; i < 8; i++) if (rgb === bars[i]) cnt[i]++;
      end
      chk($sformatf("bars_x%0d", x), rgb, e);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("bar_width_%0d", i), 24'(cnt[i]), 24'd80);

    // Checkerboard: bring frame_count to 32 so s = 32*32 mod 1024 = 0
    mode = 3'd2;
    fs_pump(31);
    chk("chk_fc32", {8'h0, frame_count}, 24'd32);
    chk("chk_mode", {21'h0, active_mode}, 24'd2);
    step(160, 45);
    chk("chk_s0_160_45", rgb, 24'h000000);
    step(191, 45);
    chk("chk_s0_191_45", rgb, 24'h000000);
    step(192, 45);
    chk("chk_s0_192_45", rgb, 24'hFFFFFF);
    step(160, 77);
    chk("chk_s0_160_77", rgb, 24'hFFFFFF);
    step(192, 77);
    chk("chk_s0_192_77", rgb, 24'h000000);
    step(159, 45);
    chk("chk_outside", rgb, 24'h000000);
    // frame_count 33 -> s = 32
    fs_pump(1);
    step(160, 45);
    chk("chk_s32_160_45", rgb, 24'hFFFFFF);
    step(192, 45);
    chk("chk_s32_192_45", rgb, 24'h000000);

    // Grey ramp: frame_count 64 -> s = 0
    mode = 3'd3;
    fs_pump(31);
    chk("ramp_fc64", {8'h0, frame_count}, 24'd64);
    step(160, 45);
    chk("ramp_160", rgb, 24'h000000);
    step(170, 50);
    chk("ramp_170", rgb, 24'h0A0A0A);
    step(415, 45);
    chk("ramp_415", rgb, 24'hFFFFFF);
    step(416, 45);
    chk("ramp_416_wrap", rgb, 24'h000000);
    step(100, 45);
    chk("ramp_outside", rgb, 24'h000000);
    // frame_count 65 -> s = 2080 mod 1024 = 32
    fs_pump(1);
    step(160, 45);
    chk("ramp_s32_160", rgb, 24'h202020);
    step(400, 45);
    chk("ramp_s32_400", rgb, 24'h101010);

    // Modes 4..7 are black
    mode = 3'd5;
    fs_pump(1);
    chk("mode5_latched", {21'h0, active_mode}, 24'd5);
    step(160, 45);
    chk("mode5_black", rgb, 24'h000000);

    // frame_count wrap
    mode = 3'd0;
    fs_pump(65535 - 66);
    chk("pre_wrap_fc", {8'h0, frame_count}, 24'd65535);
    step(0, 0);
    chk("wrap_fc", {8'h0, frame_count}, 24'd0);
    chk("wrap_rgb", rgb, 24'h000000);
    step(160, 45);
    chk("post_wrap_rgb", rgb, 24'hFFFF00);
    chk("post_wrap_mode", {21'h0, active_mode}, 24'd0);

    // Reset mid-frame from a non-border mode
    mode = 3'd2;
    step(0, 0);
    step(160, 45);
    chk("pre_reset_chk", rgb, 24'hFFFFFF);
    reset = 1'b1;
    step(160, 45);
    chk("mid_reset_rgb", rgb, 24'h000000);
    chk("mid_reset_mode", {21'h0, active_mode}, 24'd0);
    chk("mid_reset_fc", {8'h0, frame_count}, 24'd0);
    reset = 1'b0;
    step(160, 45);
    chk("post_reset_border", rgb, 24'hFFFF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
